// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for core data accesses: valid/ready request and response
// channels around a word array, with a fixed number of wait states before each access.
module riscv_dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wr_en,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [3:0]      i_req_byte_sel,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  accept_s;
  logic                  access_err_s;
  logic [DEPTH_LOG2-1:0] word_idx_s;
  logic                  addr_lsb_unused_s;

  logic                  wr_en_r;
  logic [XLEN-1:2]       addr_r;
  logic [XLEN-1:0]       wdata_r;
  logic [3:0]            byte_sel_r;
  logic [3:0]            cnt_r;
  logic                  rsp_valid_r;
  logic [XLEN-1:0]       rsp_rdata_r;
  logic                  rsp_err_r;
  logic [XLEN-1:0]       mem_r [DEPTH];

  // Out-of-range word address, or a store that enables no lane at all.
  function automatic logic access_error(input logic [XLEN-1:2] addr,
                                        input logic            wr_en,
                                        input logic [3:0]      byte_sel);
    return (|addr[XLEN-1:DEPTH_LOG2+2]) | (wr_en & ~(|byte_sel));
  endfunction

  // Byte offset is the MEM stage's concern; only the word address is kept.
  assign addr_lsb_unused_s = ^i_req_addr[1:0];

  assign word_idx_s   = addr_r[DEPTH_LOG2+1:2];
  assign access_err_s = access_error(addr_r, wr_en_r, byte_sel_r);

  assign o_req_ready = (state_r == S_IDLE) & ~i_rst;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_rdata = rsp_rdata_r;
  assign o_rsp_err   = rsp_err_r;

  // Next-state logic and request acceptance strobe.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_req_valid) begin
          accept_s = 1'b1;
          state_s  = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = S_ACCESS;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ACCESS: state_s = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_en_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      byte_sel_r  <= 4'd0;
      cnt_r       <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_en_r    <= i_req_wr_en;
        addr_r     <= i_req_addr[XLEN-1:2];
        wdata_r    <= i_req_wdata;
        byte_sel_r <= i_req_byte_sel;
        cnt_r      <= CNT_INIT;
      end
      case (state_r)
        S_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_ACCESS: begin
          rsp_valid_r <= 1'b1;
          if (access_err_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
          end else if (wr_en_r) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
          end else begin
            rsp_rdata_r <= mem_r[word_idx_s];
            rsp_err_r   <= 1'b0;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Array write; a reset during WAIT/ACCESS leaves state_r in IDLE so the store is dropped.
  always_ff @(posedge i_clk) begin
    if ((state_r == S_ACCESS) && wr_en_r && !access_err_s) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_sel_r[k]) begin
          mem_r[word_idx_s][8*k +: 8] <= wdata_r[8*k +: 8];
        end
      end
    end
  end

endmodule
